// File: rtl/alu_arbiter_if.sv
// Bundle between the two requesters, the shared ALU and the response consumer
// of alu_arbiter. slave = arbiter side, master = environment side.
interface alu_arbiter_if;
   localparam int unsigned DW   = 8;
   localparam int unsigned NREQ = 2;

   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*DW-1:0] req_a;
   logic [NREQ*DW-1:0] req_b;
   logic [NREQ*DW-1:0] req_op;
   logic [DW-1:0]      alu_a;
   logic [DW-1:0]      alu_b;
   logic [DW-1:0]      alu_sel;
   logic [DW-1:0]      alu_x;
   logic [DW-1:0]      alu_flags;
   logic               rsp_valid;
   logic               rsp_ready;
   logic               rsp_id;
   logic [DW-1:0]      rsp_x;
   logic [DW-1:0]      rsp_flags;
   logic               rsp_err;

   modport slave (
      input  req_valid, req_a, req_b, req_op, alu_x, alu_flags, rsp_ready,
      output req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_id, rsp_x, rsp_flags, rsp_err
   );

   modport master (
      output req_valid, req_a, req_b, req_op, alu_x, alu_flags, rsp_ready,
      input  req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_id, rsp_x, rsp_flags, rsp_err
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional illegal-opcode check enabled by macro ALU_ARBITER_OPCHECK_EN.
module alu_arbiter (
   input  logic         clk,
   input  logic         rst,
   alu_arbiter_if.slave bus
);
   localparam int unsigned DW   = 8;
   localparam int unsigned NREQ = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e          state_q;
   logic            last_grant_q;
   logic            id_q;
   logic            rsp_valid_q;
   logic [DW-1:0]   a_q;
   logic [DW-1:0]   b_q;
   logic [DW-1:0]   op_q;
   logic [DW-1:0]   x_q;
   logic [DW-1:0]   flags_q;

   logic            grant_d;
   logic [DW-1:0]   a_d;
   logic [DW-1:0]   b_d;
   logic [DW-1:0]   op_d;
   logic [NREQ-1:0] ready_d;

   // Grant selection: a tie goes to the requester that did not win last time.
   always_comb begin
      grant_d = bus.req_valid[1];
      if (bus.req_valid == 2'b11) begin
         grant_d = ~last_grant_q;
      end
      a_d  = grant_d ? bus.req_a[2*DW-1:DW]  : bus.req_a[DW-1:0];
      b_d  = grant_d ? bus.req_b[2*DW-1:DW]  : bus.req_b[DW-1:0];
      op_d = grant_d ? bus.req_op[2*DW-1:DW] : bus.req_op[DW-1:0];
      ready_d = '0;
      if (!rst && (state_q == IDLE) && (|bus.req_valid)) begin
         ready_d = grant_d ? 2'b10 : 2'b01;
      end
   end

`ifdef ALU_ARBITER_OPCHECK_EN
   logic rsp_err_q;
   logic op_legal_d;
   assign op_legal_d = (op_q >= 8'h01) && (op_q <= 8'h0F);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         rsp_valid_q  <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         x_q          <= '0;
         flags_q      <= '0;
`ifdef ALU_ARBITER_OPCHECK_EN
         rsp_err_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (|bus.req_valid) begin
                  a_q          <= a_d;
                  b_q          <= b_d;
                  op_q         <= op_d;
                  id_q         <= grant_d;
                  last_grant_q <= grant_d;
                  state_q      <= EXEC;
               end
            end
            EXEC: begin
`ifdef ALU_ARBITER_OPCHECK_EN
               // Illegal ops bypass the ALU and report a zeroed, flagged result.
               if (op_legal_d) begin
                  x_q       <= bus.alu_x;
                  flags_q   <= bus.alu_flags;
                  rsp_err_q <= 1'b0;
               end else begin
                  x_q       <= '0;
                  flags_q   <= '0;
                  rsp_err_q <= 1'b1;
               end
`else
               x_q     <= bus.alu_x;
               flags_q <= bus.alu_flags;
`endif
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               rsp_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready = ready_d;
   assign bus.alu_a     = a_q;
   assign bus.alu_b     = b_q;
   assign bus.alu_sel   = op_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = id_q;
   assign bus.rsp_x     = x_q;
   assign bus.rsp_flags = flags_q;
`ifdef ALU_ARBITER_OPCHECK_EN
   assign bus.rsp_err   = rsp_err_q;
`else
   assign bus.rsp_err   = 1'b0;
`endif
endmodule
